adc_ltc2320_emulator: RTL and testbench

//  Synthesizable responder model of the 8-channel, 16-bit serial ADC driven by adcControl.

---
 rtl/adc_ltc2320_emulator_if.sv | 22 ++
 rtl/adc_ltc2320_emulator.sv | 171 +++++++++++++++++
 tb/tb_adc_ltc2320_emulator.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/adc_ltc2320_emulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_ltc2320_emulator_if
//  Description : Controller <-> ADC emulator signal bundle (CNV/SCK in,
//                SDO/CLKOUT/status out, channel sample source).
//  Revision    : 1.0  initial release
// ============================================================================
interface adc_ltc2320_emulator_if #(
    parameter int DATA_W = 16
);
    logic                cnv;
    logic                sck;
    logic [8*DATA_W-1:0] ch_data;
    logic [7:0]          sdo;      // sdo[k] is SDO(k+1)
    logic                clkout;
    logic                busy;
    logic                err_cnv;

    modport master (output cnv, sck, ch_data, input sdo, clkout, busy, err_cnv);
    modport slave  (input cnv, sck, ch_data, output sdo, clkout, busy, err_cnv);
endinterface
`default_nettype wire

// File: rtl/adc_ltc2320_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : adc_ltc2320_emulator
//  Description : Responder model of an 8-channel serial ADC: conversion timer,
//                MSB-first readout on 8 SDO lines, delayed CLKOUT echo.
//                Define CH_PATTERN_EN to replace CH_DATA with a counter pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module adc_ltc2320_emulator #(
    parameter int DATA_W      = 16,
    parameter int CONV_CYCLES = 45,
    parameter int CLKOUT_DLY  = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    adc_ltc2320_emulator_if.slave bus
);
    localparam int c_tmr_w = $clog2(CONV_CYCLES + 1);
    localparam int c_cnt_w = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_READY   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_cnv_q, r_cnv_prev, r_sck_q, r_sck_prev;
    logic                   w_cnv_rise, w_sck_rise, w_accept;
    logic [7:0][DATA_W-1:0] r_shreg, w_shreg_nxt, w_sample;
    logic [c_tmr_w-1:0]     r_timer, w_timer_nxt;
    logic [c_cnt_w-1:0]     r_bitcnt, w_bitcnt_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_err, w_err_nxt;
    logic [7:0]             r_sdo, w_sdo_nxt;

    assign w_cnv_rise = r_cnv_q & ~r_cnv_prev;
    assign w_sck_rise = r_sck_q & ~r_sck_prev;

`ifdef CH_PATTERN_EN
    logic [DATA_W-1:0] r_conv_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conv_cnt <= '0;
        end else if (w_accept) begin
            r_conv_cnt <= r_conv_cnt + DATA_W'(1);
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_pattern
        assign w_sample[k] = r_conv_cnt + DATA_W'(k * 4096);
    end
`else
    assign w_sample = bus.ch_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnv_q    <= 1'b0;
            r_cnv_prev <= 1'b0;
            r_sck_q    <= 1'b0;
            r_sck_prev <= 1'b0;
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_timer    <= '0;
            r_bitcnt   <= '0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_sdo      <= '0;
        end else begin
            r_cnv_q    <= bus.cnv;
            r_cnv_prev <= r_cnv_q;
            r_sck_q    <= bus.sck;
            r_sck_prev <= r_sck_q;
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_timer    <= w_timer_nxt;
            r_bitcnt   <= w_bitcnt_nxt;
            r_busy     <= w_busy_nxt;
            r_err      <= w_err_nxt;
            r_sdo      <= w_sdo_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_timer_nxt  = r_timer;
        w_bitcnt_nxt = r_bitcnt;
        w_busy_nxt   = r_busy;
        w_err_nxt    = r_err;
        w_sdo_nxt    = '0;
        w_accept     = 1'b0;

        case (r_state)
            S_CONVERT: begin
                if (w_cnv_rise) begin
                    w_err_nxt = 1'b1;
                end
                if (r_timer == '0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_READY;
                    for (int k = 0; k < 8; k++) begin
                        w_sdo_nxt[k] = r_shreg[k][DATA_W-1];
                    end
                end else begin
                    w_timer_nxt = r_timer - c_tmr_w'(1);
                end
            end
            S_READY: begin
                w_sdo_nxt = r_sdo;
                // CNV has priority over a coincident SCK rise
                if (w_cnv_rise) begin
                    w_accept = 1'b1;
                end else if (w_sck_rise) begin
                    w_bitcnt_nxt = r_bitcnt + c_cnt_w'(1);
                    for (int k = 0; k < 8; k++) begin
                        w_shreg_nxt[k] = {r_shreg[k][DATA_W-2:0], 1'b0};
                        w_sdo_nxt[k]   = r_shreg[k][DATA_W-2];
                    end
                    if (r_bitcnt == c_cnt_w'(DATA_W - 1)) begin
                        w_state_nxt = S_DONE;
                        w_sdo_nxt   = '0;
                    end
                end
            end
            default: begin
                if (w_cnv_rise) begin
                    w_accept = 1'b1;
                end
            end
        endcase

        if (w_accept) begin
            w_shreg_nxt  = w_sample;
            w_timer_nxt  = c_tmr_w'(CONV_CYCLES - 1);
            w_bitcnt_nxt = '0;
            w_busy_nxt   = 1'b1;
            w_sdo_nxt    = '0;
            w_state_nxt  = S_CONVERT;
        end
    end

    generate
        if (CLKOUT_DLY == 0) begin : g_clkout_pass
            assign bus.clkout = bus.sck;
        end else begin : g_clkout_dly
            logic [CLKOUT_DLY-1:0] r_dly;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly[0] <= bus.sck;
                    for (int i = 1; i < CLKOUT_DLY; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end

            assign bus.clkout = r_dly[CLKOUT_DLY-1];
        end
    endgenerate

    assign bus.sdo     = r_sdo;
    assign bus.busy    = r_busy;
    assign bus.err_cnv = r_err;
endmodule
`default_nettype wire

// File: tb/tb_adc_ltc2320_emulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_ltc2320_emulator
//  Description : Directed bench with a cycle-level behavioural model of the
//                ADC emulator and literal checks on readout words and timing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_ltc2320_emulator;
    localparam int c_dw   = 16;
    localparam int c_conv = 45;
    localparam int P_IDLE = 0, P_CONV = 1, P_READY = 2, P_DONE = 3;

    typedef logic [7:0][c_dw-1:0] words_t;

    localparam words_t c_data_a = {16'h8001, 16'h7E7E, 16'h0F0F, 16'hFFFF,
                                   16'h0000, 16'h5A5A, 16'h1234, 16'hA5C3};
    localparam words_t c_data_b = {16'h7FFE, 16'h1111, 16'h2222, 16'h3333,
                                   16'h4444, 16'h5555, 16'h6666, 16'h3C96};

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   checking = 1'b0;

    adc_ltc2320_emulator_if #(.DATA_W(c_dw)) bus ();

    adc_ltc2320_emulator #(
        .DATA_W      (c_dw),
        .CONV_CYCLES (c_conv),
        .CLKOUT_DLY  (1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pins become visible one clock late, an edge acts one clock after that
    int     m_phase, m_cnt, m_bit;
    bit     m_err, m_clkout, m_cr, m_sr;
    bit     h_cnv1, h_cnv2, h_sck1, h_sck2;
    words_t m_words;
    logic [c_dw-1:0] m_conv_no;

    function automatic words_t model_sample();
        words_t s;
`ifdef CH_PATTERN_EN
        for (int k = 0; k < 8; k++) s[k] = m_conv_no + c_dw'(k * 4096);
`else
        s = bus.ch_data;
`endif
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = P_IDLE; m_cnt = 0; m_bit = 0; m_err = 1'b0;
            m_words = '0; m_conv_no = '0; m_clkout = 1'b0;
            h_cnv1 = 1'b0; h_cnv2 = 1'b0; h_sck1 = 1'b0; h_sck2 = 1'b0;
        end else begin
            m_cr = h_cnv1 & ~h_cnv2;
            m_sr = h_sck1 & ~h_sck2;
            if (m_cr && m_phase == P_CONV) m_err = 1'b1;
            if (m_cr && m_phase != P_CONV) begin
                m_words = model_sample();
                m_conv_no++;
                m_phase = P_CONV;
                m_cnt = 1;
            end else if (m_phase == P_CONV) begin
                if (m_cnt == c_conv) begin
                    m_phase = P_READY;
                    m_bit = 0;
                end else begin
                    m_cnt++;
                end
            end else if (m_phase == P_READY && m_sr) begin
                m_bit++;
                if (m_bit == c_dw) m_phase = P_DONE;
            end
            h_cnv2 = h_cnv1; h_cnv1 = bus.cnv;
            h_sck2 = h_sck1; h_sck1 = bus.sck;
            m_clkout = bus.sck;
        end
    end

    always @(posedge clk) begin
        logic [7:0] e_sdo;
        #1;
        if (checking) begin
            e_sdo = '0;
            if (m_phase == P_READY) begin
                for (int k = 0; k < 8; k++) e_sdo[k] = m_words[k][c_dw-1-m_bit];
            end
            check("sdo", bus.sdo, e_sdo);
            check("busy", bus.busy, m_phase == P_CONV);
            check("err_cnv", bus.err_cnv, m_err);
            check("clkout", bus.clkout, m_clkout);
        end
    end

    task automatic sck_pulse();
        bus.sck = 1'b1;
        @(negedge clk);
        bus.sck = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_conv(input bit noise, input bit second, output int cyc, output int first);
        bit seen;
        seen = 1'b0; cyc = 0; first = -1;
        bus.cnv = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 1) bus.cnv = 1'b0;
            if (bus.busy) begin
                if (!seen) first = i;
                seen = 1'b1;
                cyc++;
            end else if (seen) begin
                break;
            end
            bus.sck = (noise && seen && cyc < 40) ? ~bus.sck : 1'b0;
            if (second && cyc == 20) begin
                bus.cnv = 1'b1;
                bus.ch_data = ~bus.ch_data;
            end
            if (second && cyc == 22) bus.cnv = 1'b0;
        end
        bus.sck = 1'b0;
        check("conv_complete", {30'd0, seen, bus.busy}, 32'd2);
    endtask

    task automatic readout(input int nbits, output words_t w);
        w = '0;
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < 8; k++) w[k][c_dw-1-i] = bus.sdo[k];
            sck_pulse();
        end
    endtask

    initial begin
        words_t w;
        int     cyc, first;
        rst = 1'b1;
        bus.cnv = 1'b0;
        bus.sck = 1'b0;
        bus.ch_data = c_data_a;
        checking = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_sdo", bus.sdo, 0);
        check("rst_err", bus.err_cnv, 0);
        check("rst_clkout", bus.clkout, 0);

`ifdef CH_PATTERN_EN
        for (int n = 0; n < 3; n++) begin
            do_conv(1'b0, 1'b0, cyc, first);
            readout(16, w);
            check("pat_ch0", w[0], n);
            check("pat_ch3", w[3], 32'h3000 + n);
        end
`else
        // Basic readout and timing
        do_conv(1'b0, 1'b0, cyc, first);
        check("t1_latency", first, 1);
        check("t1_busy_cycles", cyc, 45);
        readout(16, w);
        check("t1_sdo1", w[0], 16'hA5C3);
        check("t1_sdo8", w[7], 16'h8001);
        check("t1_sdo_after", bus.sdo, 0);
        check("t1_err", bus.err_cnv, 0);

        // SCK activity during conversion must not shift
        do_conv(1'b1, 1'b0, cyc, first);
        check("t2_busy_cycles", cyc, 45);
        check("t2_first_bit", bus.sdo[0], 1);
        readout(16, w);
        check("t2_sdo1", w[0], 16'hA5C3);
        check("t2_sdo8", w[7], 16'h8001);

        // Second CNV during conversion: flagged, original timing and data kept
        do_conv(1'b0, 1'b1, cyc, first);
        check("t3_busy_cycles", cyc, 45);
        check("t3_err", bus.err_cnv, 1);
        readout(16, w);
        check("t3_sdo1", w[0], 16'hA5C3);
        check("t3_sdo8", w[7], 16'h8001);
        bus.ch_data = c_data_a;

        // Abort mid-readout with coincident SCK rise; new data from MSB
        do_conv(1'b0, 1'b0, cyc, first);
        readout(5, w);
        check("t4_partial", w[0][15:11], 5'b10100);
        bus.ch_data = c_data_b;
        bus.sck = 1'b1;
        do_conv(1'b0, 1'b0, cyc, first);
        check("t4_latency", first, 1);
        check("t4_busy_cycles", cyc, 45);
        readout(16, w);
        check("t4_sdo1", w[0], 16'h3C96);
        check("t4_sdo8", w[7], 16'h7FFE);
        check("t4_err_sticky", bus.err_cnv, 1);

        // Reset mid-readout, then extra SCK in DONE
        do_conv(1'b0, 1'b0, cyc, first);
        readout(8, w);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_sdo", bus.sdo, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_err", bus.err_cnv, 0);
        do_conv(1'b0, 1'b0, cyc, first);
        readout(16, w);
        check("t5_sdo1", w[0], 16'h3C96);
        sck_pulse();
        check("t5_done_sdo", bus.sdo, 0);
`endif
        repeat (4) @(negedge clk);
        checking = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
